interlock_timer: RTL
====================

// Module: interlock_timer
// PURPOSE
//  Elapsed-seconds timer feeding the interlock exit/entry FSMs. Restarted by the FSM's
//  rstCounter pulse. Divides the board clock into 1 s ticks, counts elapsed seconds and
//  reports the 5 s / 7 s / 8 s milestones as a one-hot counterVal. The FSM consumes
//  counterVal directly, so counterVal is registered.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clock cycles per second; benches override with 4
//  MAX_SEC        15          seconds value at which counting saturates; must be >= 8 and <= 15
// PORTS
//  clock       in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  rstCounter  in   1  restart request from FSM; single-cycle pulse or level
//  counterVal  out  3  one-hot milestone: 001 = 5 s, 010 = 7 s, 100 = 8 s, else 000
//  seconds     out  4  elapsed whole seconds since last restart
//  tick        out  1  one-cycle pulse on each seconds increment
//  running     out  1  1 while counting; 0 in IDLE and SAT
//  hex         out  7  active-low 7-seg of seconds; all-ones when feature compiled out
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, seconds=0, counterVal=000, tick=0, running=0,
//   hex=7'b1111111. rst overrides rstCounter.
//  States:
//   IDLE: counts nothing.
//   RUN:  prescaler counts 0..TICKS_PER_SEC-1. At terminal count the prescaler wraps to 0,
//         seconds is incremented and tick=1 for that cycle.
//   SAT:  seconds held at MAX_SEC; no ticks.
//  Transitions:
//   any state, rstCounter=1 -> RUN, with prescaler=0, seconds=0, counterVal=000 on the next edge.
//     rstCounter held high keeps the block in restart: the count never advances.
//   RUN -> SAT on the edge where seconds becomes MAX_SEC.
//  Latency:
//   - First tick arrives exactly TICKS_PER_SEC cycles after the edge sampling rstCounter
//     falling to 0.
//   - counterVal and seconds update on the same edge (decoded from the next seconds value):
//     zero lag between them.
//  counterVal is a level, asserted only while seconds is exactly 5, 7 or 8.
//   - seconds 6 and >=9 give 000, so a 7 s wait is never satisfied early by the 5 s code.
//  Simultaneous events: rstCounter on a terminal-count cycle wins. There is no increment and
//   no tick.
//  seconds never wraps; it saturates.
//  TICKS_PER_SEC=1 is legal: tick on every RUN cycle.
// CONFIGURATION
//  INTERLOCK_TIMER_HEX_EN defined:
//   - hex is registered and shows seconds 0-F in active-low 7-seg (0=7'b1000000 ... F=7'b0001110).
//   - hex updates on the same edge as seconds; reset shows 0 (7'b1000000).
//  Not defined: hex tied to 7'b1111111 and no decoder logic is generated.
// STRUCTURE
//  interlock_pkg:
//   - one-hot constants CNT_FIVE=3'b001, CNT_SEVEN=3'b010, CNT_EIGHT=3'b100;
//   - timer state enum {IDLE, RUN, SAT};
//   - 16-entry 7-seg digit table; function for seconds -> counterVal decode.
//  Sub-module tick_prescaler:
//   - parameter TICKS_PER_SEC;
//   - inputs clock, rst, clr, en; output tick;
//   - counter width $clog2(TICKS_PER_SEC) minimum 1.
// TESTING (TICKS_PER_SEC=4)
//  1. rst 2 cycles -> counterVal=000, seconds=0, running=0, hex=7'b1111111
//     (7'b1000000 with HEX_EN).
//  2. rstCounter 1-cycle pulse -> running=1; tick every 4th cycle. counterVal=001 for exactly
//     4 cycles starting cycle 20, then 000 for seconds=6.
//  3. Continue -> counterVal=010 at seconds=7, 100 at seconds=8, 000 at seconds 9.
//     seconds sticks at 15, running=0, no further tick.
//  4. rstCounter asserted on a terminal-count cycle at seconds=4 -> no tick, seconds=0 next
//     cycle, counterVal stays 000.
//  5. rstCounter held high 10 cycles -> seconds=0, tick=0 throughout. Release -> first tick
//     4 cycles later.
//  6. rst asserted mid-RUN at seconds=7 together with rstCounter -> IDLE, counterVal=000,
//     running=0; no counting until next rstCounter.

Source files
------------

// File: rtl/interlock_timer_pkg.sv
// Shared constants, state type, 7-seg table and milestone decode for the
// interlock elapsed-seconds timer.
package interlock_pkg;

  // One-hot milestone codes consumed by the interlock FSMs
  localparam logic [2:0] CNT_FIVE  = 3'b001;
  localparam logic [2:0] CNT_SEVEN = 3'b010;
  localparam logic [2:0] CNT_EIGHT = 3'b100;
  localparam logic [2:0] CNT_NONE  = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAT
  } timer_state_t;

  // Active-low 7-segment patterns (gfedcba) for digits 0..F
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Milestone is a level: only exactly 5, 7 or 8 seconds produce a code
  function automatic logic [2:0] sec_to_cnt(input logic [3:0] s);
    logic [2:0] c;
    c = CNT_NONE;
    case (s)
      4'd5:    c = CNT_FIVE;
      4'd7:    c = CNT_SEVEN;
      4'd8:    c = CNT_EIGHT;
      default: c = CNT_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/interlock_timer_if.sv
// Timer <-> interlock FSM signal bundle. The FSM (master) issues restart
// requests; the timer (slave) reports milestones and status.
interface interlock_timer_if;
  logic       rstCounter;
  logic [2:0] counterVal;
  logic [3:0] seconds;
  logic       tick;
  logic       running;
  logic [6:0] hex;

  modport master (
    output rstCounter,
    input  counterVal, seconds, tick, running, hex
  );

  modport slave (
    input  rstCounter,
    output counterVal, seconds, tick, running, hex
  );
endinterface

// File: rtl/interlock_timer_prescaler.sv
// Divides the board clock into one-second ticks. tick is combinational and
// marks the terminal-count cycle while enabled and not being cleared.
module tick_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          term;

  // Next count: clear wins, otherwise wrap at terminal count while enabled
  always_comb begin
    term  = (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clr && term;

  // Prescaler counter register
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/interlock_timer.sv
// Elapsed-seconds timer for the interlock FSMs. Restarted by rstCounter,
// counts seconds up to MAX_SEC and reports 5/7/8 s milestones one-hot.
// Optional 7-seg output enabled by defining INTERLOCK_TIMER_HEX_EN.
module interlock_timer
  import interlock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned MAX_SEC       = 15
) (
  input  logic               clock,
  input  logic               rst,
  interlock_timer_if.slave   bus
);
  localparam logic [3:0] MAX_S = 4'(MAX_SEC);

  timer_state_t state_q;
  logic [3:0]   seconds_q;
  logic [3:0]   seconds_d;
  logic [2:0]   cnt_val_q;
  logic         tick_q;
  logic         running_q;
  logic         pre_tick;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clock (clock),
    .rst   (rst),
    .clr   (bus.rstCounter),
    .en    (state_q == RUN),
    .tick  (pre_tick)
  );

  // Candidate seconds value for the increment edge
  always_comb begin
    seconds_d = seconds_q + 4'd1;
  end

  // Timer FSM; milestone code is decoded from the next seconds value so it
  // changes on the same edge as seconds
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      seconds_q <= '0;
      cnt_val_q <= CNT_NONE;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else if (bus.rstCounter) begin
      state_q   <= RUN;
      seconds_q <= '0;
      cnt_val_q <= CNT_NONE;
      tick_q    <= 1'b0;
      running_q <= 1'b1;
    end else begin
      tick_q <= pre_tick;
      if (pre_tick) begin
        seconds_q <= seconds_d;
        cnt_val_q <= sec_to_cnt(seconds_d);
        if (seconds_d == MAX_S) begin
          state_q   <= SAT;
          running_q <= 1'b0;
        end
      end
    end
  end

`ifdef INTERLOCK_TIMER_HEX_EN
  logic [6:0] hex_q;

  // 7-seg display register tracking seconds on the same edge
  always_ff @(posedge clock) begin
    if (rst) begin
      hex_q <= SEG7_TABLE[0];
    end else if (bus.rstCounter) begin
      hex_q <= SEG7_TABLE[0];
    end else if (pre_tick) begin
      hex_q <= SEG7_TABLE[seconds_d];
    end
  end

  assign bus.hex = hex_q;
`else
  assign bus.hex = '1;
`endif

  assign bus.counterVal = cnt_val_q;
  assign bus.seconds    = seconds_q;
  assign bus.tick       = tick_q;
  assign bus.running    = running_q;
endmodule
